// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-code transmitter and its future receiver.
// Holds the frame state encoding, line levels and counter-width helper.
package rep_code_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    localparam int DEFAULT_REP = 5;

    // Counter width for a count range of 0..max_count-1, never below one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/rep5_code_tx_chip_timer.sv
// Clock divider that marks the last clk cycle of every chip with a one-cycle strobe.
// Held at zero while cleared; counts only while enabled.
module chip_timer
    import rep_code_pkg::*;
#(
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic chip_end
);

    localparam int CNT_W = cnt_width(CLKS_PER_CHIP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_CHIP - 1);

    logic [CNT_W-1:0] clk_cnt;

    assign chip_end = en && (clk_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
        end else if (clr) begin
            clk_cnt <= '0;
        end else if (en) begin
            clk_cnt <= (clk_cnt == CNT_LAST) ? '0 : clk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rep5_code_tx.sv
// Repetition-code serial transmitter: start, DATA_W bits LSB first, stop,
// each frame bit sent REP times as chips of CLKS_PER_CHIP clk cycles.
module rep5_code_tx
    import rep_code_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int REP           = DEFAULT_REP,
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              done
);

    if ((REP % 2) == 0 || REP < 3 || CLKS_PER_CHIP < 1 || DATA_W < 1) begin : g_bad_params
        $error("rep5_code_tx: REP must be odd and >= 3, CLKS_PER_CHIP and DATA_W >= 1");
    end

    localparam int CHIP_W = cnt_width(REP);
    localparam int BIT_W  = cnt_width(DATA_W);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(REP - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CHIP_W-1:0] chip_q, chip_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              line_d;
    logic              done_d;
    logic              chip_end;
    logic              bit_end;

    chip_timer #(
        .CLKS_PER_CHIP(CLKS_PER_CHIP)
    ) u_chip_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_q != IDLE),
        .clr     (state_q == IDLE),
        .chip_end(chip_end)
    );

    assign bit_end  = chip_end && (chip_q == CHIP_LAST);
    assign in_ready = rst_n && (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        chip_d  = chip_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        line_d  = LINE_IDLE;

        if (chip_end) begin
            chip_d = (chip_q == CHIP_LAST) ? '0 : chip_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = START;
                    shift_d = in_data;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from next-state values so the registered output lines up with the state.
        case (state_d)
            START:   line_d = LINE_START;
            DATA:    line_d = shift_d[0];
            STOP:    line_d = LINE_STOP;
            default: line_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            chip_q  <= '0;
            bit_q   <= '0;
            tx_out  <= LINE_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            chip_q  <= chip_d;
            bit_q   <= bit_d;
            tx_out  <= line_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_rep5_code_tx.sv
// Directed and randomized checks of rep5_code_tx against a frame-level line model.
module tb_rep5_code_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       done;

    logic [3:0] in_data2;
    logic       in_valid2;
    logic       in_ready2;
    logic       tx_out2;
    logic       tx_busy2;
    logic       done2;

    int total = 0;
    int bad   = 0;

    localparam int N1 = 50;
    localparam int N2 = 54;

    rep5_code_tx #(
        .DATA_W(8),
        .REP(5),
        .CLKS_PER_CHIP(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx_out  (tx_out),
        .tx_busy (tx_busy),
        .done    (done)
    );

    rep5_code_tx #(
        .DATA_W(4),
        .REP(3),
        .CLKS_PER_CHIP(3)
    ) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data2),
        .in_valid(in_valid2),
        .in_ready(in_ready2),
        .tx_out  (tx_out2),
        .tx_busy (tx_busy2),
        .done    (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level in cycle k (1-based) after the accept edge.
    function automatic logic exp_line(input logic [31:0] d, input int k,
                                      input int dw, input int rep, input int cpc);
        int idx;
        idx = (k - 1) / (rep * cpc);
        if (idx == 0) return 1'b0;
        if (idx <= dw) return d[idx-1];
        return 1'b1;
    endfunction

    // Sends one word on the default instance and checks every cycle through the done cycle.
    task automatic frame1(input logic [7:0] d, input bit hold, input logic [7:0] nxt,
                          input int pulse_at);
        in_data  = d;
        in_valid = 1'b1;
        chk("pre_ready", 32'(in_ready), 32'd1);
        for (int k = 1; k <= N1 + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if (hold) in_data = nxt;
                else in_valid = 1'b0;
            end
            if (k == pulse_at) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
            end
            if (k == pulse_at + 1) begin
                in_valid = 1'b0;
                in_data  = d;
            end
            if (k <= N1) begin
                chk($sformatf("line d=%0h k=%0d", d, k), 32'(tx_out),
                    32'(exp_line(32'(d), k, 8, 5, 1)));
                chk($sformatf("busy k=%0d", k), 32'(tx_busy), 32'd1);
                chk($sformatf("no_done k=%0d", k), 32'(done), 32'd0);
                chk($sformatf("not_ready k=%0d", k), 32'(in_ready), 32'd0);
            end else begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("ready_at_done", 32'(in_ready), 32'd1);
                chk("idle_not_busy", 32'(tx_busy), 32'd0);
                chk("idle_line", 32'(tx_out), 32'd1);
            end
        end
    endtask

    initial begin
        logic [7:0] rnd;
        logic       line2 [1:N2];
        int         busy_cnt;
        int         votes;
        logic [3:0] recovered;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_valid2 = 1'b0;
        in_data2  = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_line", 32'(tx_out), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        frame1(8'hA5, 1'b0, 8'h00, -5);
        frame1(8'hA5, 1'b0, 8'h00, 20);

        frame1(8'h00, 1'b1, 8'hFF, -5);
        frame1(8'hFF, 1'b0, 8'h00, -5);

        repeat (4) begin
            rnd = 8'($urandom_range(0, 255));
            frame1(rnd, 1'b0, 8'h00, -5);
        end

        // Abort a frame at cycle 17.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("abort_line k=%0d", k), 32'(tx_out),
                32'(exp_line(32'h0A5, k, 8, 5, 1)));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_line_high", 32'(tx_out), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done_rst", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("abort_ready", 32'(in_ready), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort_no_done_idle", 32'(done), 32'd0);
            chk("abort_idle_line", 32'(tx_out), 32'd1);
        end
        frame1(8'h81, 1'b0, 8'h00, -5);

        // Slow-chip instance: REP=3, three clocks per chip, 4-bit payload.
        in_data2  = 4'h6;
        in_valid2 = 1'b1;
        chk("d2_pre_ready", 32'(in_ready2), 32'd1);
        busy_cnt = 0;
        for (int k = 1; k <= N2 + 1; k++) begin
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            if (tx_busy2) busy_cnt++;
            if (k <= N2) begin
                line2[k] = tx_out2;
                chk($sformatf("d2_line k=%0d", k), 32'(tx_out2),
                    32'(exp_line(32'h6, k, 4, 3, 3)));
                chk($sformatf("d2_no_done k=%0d", k), 32'(done2), 32'd0);
            end else begin
                chk("d2_done", 32'(done2), 32'd1);
                chk("d2_ready", 32'(in_ready2), 32'd1);
            end
        end
        chk("d2_frame_len", 32'(busy_cnt), 32'(N2));
        recovered = '0;
        for (int b = 0; b < 4; b++) begin
            votes = 0;
            for (int c = 0; c < 3; c++) begin
                if (line2[((1 + b) * 3 + c) * 3 + 2] === 1'b1) votes++;
            end
            recovered[b] = (votes >= 2);
        end
        chk("d2_majority", 32'(recovered), 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
